// File: rtl/pico_cmd_pkg.sv
// Shared PICO_MIPS command definitions: field widths, the packed command
// layout, a packing helper and the loader state encoding.
package pico_cmd_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 5;
    localparam int IMM_W = 8;
    localparam int CMD_W = OP_W + 2 * REG_W + IMM_W;

    // [23:18] opcode, [17:13] destination, [12:8] source, [7:0] immediate
    typedef struct packed {
        logic [OP_W-1:0]  op_code;
        logic [REG_W-1:0] des_addr;
        logic [REG_W-1:0] src_addr;
        logic [IMM_W-1:0] imme_data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

    function automatic cmd_t pack_cmd(
        input logic [OP_W-1:0]  op_code,
        input logic [REG_W-1:0] des_addr,
        input logic [REG_W-1:0] src_addr,
        input logic [IMM_W-1:0] imme_data
    );
        cmd_t c;
        c.op_code   = op_code;
        c.des_addr  = des_addr;
        c.src_addr  = src_addr;
        c.imme_data = imme_data;
        return c;
    endfunction

endpackage

// File: rtl/cmd_encoder_loader_if.sv
// Field-tuple input handshake and instruction-memory write bus.
//
// Handshake: a tuple transfers on a rising clk edge where fld_valid and
// fld_ready are both high. fld_ready depends only on registered FIFO
// occupancy (and reset), never on fld_valid. The imem side has no back
// pressure: every cycle with imem_we high is one write.
interface cmd_encoder_loader_if
    import pico_cmd_pkg::*;
#(
    parameter int IMEM_AW = 8
) ();

    logic               fld_valid;
    logic               fld_ready;
    logic [OP_W-1:0]    op_code;
    logic [REG_W-1:0]   des_addr;
    logic [REG_W-1:0]   src_addr;
    logic [IMM_W-1:0]   imme_data;
    logic               fld_last;

    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [CMD_W-1:0]   imem_wdata;

    // Host / bench side: sources fields, observes imem writes
    modport master (
        output fld_valid, op_code, des_addr, src_addr, imme_data, fld_last,
        input  fld_ready,
        input  imem_we, imem_addr, imem_wdata
    );

    // Encoder/loader side
    modport slave (
        input  fld_valid, op_code, des_addr, src_addr, imme_data, fld_last,
        output fld_ready,
        output imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Read data is the
// current head entry; a pop advances the head on the next edge.
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even when a pop happens in the same cycle
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    // Storage array, written on accepted push only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cmd_encoder_loader.sv
// Packs instruction fields into 24-bit commands, buffers them in a FIFO and
// loads them into consecutive instruction-memory addresses while holding the
// CPU halted. An overflow past the top address before the last word ends the
// load with load_err set.
module cmd_encoder_loader
    import pico_cmd_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int IMEM_AW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    cmd_encoder_loader_if.slave      bus,
    input  logic                     start,
    input  logic [IMEM_AW-1:0]       base_addr,
    output logic                     cpu_hold,
    output logic                     load_done,
    output logic                     load_err,
    output logic [IMEM_AW:0]         load_count,
    output loader_state_t            dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_fifo_count
);

    localparam int ENTRY_W = CMD_W + 1;

    loader_state_t      state_q;
    loader_state_t      state_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               head_last;
    logic [CMD_W-1:0]   head_cmd;
    logic               at_top;

    logic [IMEM_AW-1:0] addr_q;
    logic [IMEM_AW:0]   count_q;
    logic               we_q;
    logic [IMEM_AW-1:0] waddr_q;
    logic [CMD_W-1:0]   wdata_q;
    logic               done_q;
    logic               err_q;

    assign bus.fld_ready = !fifo_full && !rst;
    assign fifo_push     = bus.fld_valid && bus.fld_ready;
    assign fifo_wdata    = {bus.fld_last,
                            pack_cmd(bus.op_code, bus.des_addr,
                                     bus.src_addr, bus.imme_data)};
    assign head_last     = fifo_rdata[CMD_W];
    assign head_cmd      = fifo_rdata[CMD_W-1:0];
    assign at_top        = (addr_q == '1);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_fifo_count)
    );

    // Loader state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pop decision; pops only from registered occupancy
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_last || at_top) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load bookkeeping and the registered imem write one cycle after a pop
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (state_q != ST_LOAD && start) begin
                addr_q  <= base_addr;
                count_q <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end
            if (fifo_pop) begin
                we_q    <= 1'b1;
                waddr_q <= addr_q;
                wdata_q <= head_cmd;
                addr_q  <= addr_q + IMEM_AW'(1);
                count_q <= count_q + (IMEM_AW + 1)'(1);
                if (head_last) begin
                    done_q <= 1'b1;
                end else if (at_top) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // CPU stays halted until the final write cycle has passed
    assign cpu_hold       = (state_q != ST_DONE) || we_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign load_count     = count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_cmd_encoder_loader.sv
// Directed bench for cmd_encoder_loader: single word, prefill with back
// pressure, empty-FIFO stall, address overflow, reload and reset mid-load.
module tb_cmd_encoder_loader;
    import pico_cmd_pkg::*;

    localparam int DEPTH   = 8;
    localparam int IMEM_AW = 8;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [IMEM_AW-1:0]     base_addr;
    logic                   cpu_hold;
    logic                   load_done;
    logic                   load_err;
    logic [IMEM_AW:0]       load_count;
    loader_state_t          dbg_state;
    logic [$clog2(DEPTH):0] dbg_fifo_count;

    int vectors;
    int miscompares;

    // expected imem writes: {addr, data}
    logic [31:0] exp_q[$];

    cmd_encoder_loader_if #(.IMEM_AW(IMEM_AW)) bus ();

    cmd_encoder_loader #(
        .DEPTH   (DEPTH),
        .IMEM_AW (IMEM_AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .start          (start),
        .base_addr      (base_addr),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .load_err       (load_err),
        .load_count     (load_count),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one tuple offered for one cycle
    task automatic push(input logic [5:0] op, input logic [4:0] des, input logic [4:0] src,
                        input logic [7:0] imm, input logic last);
        bus.fld_valid = 1'b1;
        bus.op_code   = op;
        bus.des_addr  = des;
        bus.src_addr  = src;
        bus.imme_data = imm;
        bus.fld_last  = last;
        tick();
        bus.fld_valid = 1'b0;
        bus.fld_last  = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    32'(bus.imem_we), 32'd0);
        check({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
        check({tag, "_hold"},  32'(cpu_hold), 32'd1);
        check({tag, "_done"},  32'(load_done), 32'd0);
        check({tag, "_err"},   32'(load_err), 32'd0);
        check({tag, "_count"}, 32'(load_count), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, "_fifo"},  32'(dbg_fifo_count), 32'd0);
    endtask

    // scoreboard: every imem write must match the head of exp_q
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {bus.imem_addr, bus.imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("imem_write", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
            end
        end
    end

    // prefill words k=1..9: op=k, des=0, src=0, imm=8'h10+k
    logic [23:0] tbl2 [9] = '{24'h040011, 24'h080012, 24'h0C0013, 24'h100014, 24'h140015,
                              24'h180016, 24'h1C0017, 24'h200018, 24'h240019};

    // stall words
    logic [23:0] tbl3 [3] = '{24'hFFE000, 24'h001FFF, 24'h55553C};
    logic [5:0]  op3  [3] = '{6'h3F, 6'h00, 6'h15};
    logic [4:0]  des3 [3] = '{5'h1F, 5'h00, 5'h0A};
    logic [4:0]  src3 [3] = '{5'h00, 5'h1F, 5'h15};
    logic [7:0]  imm3 [3] = '{8'h00, 8'hFF, 8'h3C};

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        bus.fld_valid = 1'b0;
        bus.op_code   = '0;
        bus.des_addr  = '0;
        bus.src_addr  = '0;
        bus.imme_data = '0;
        bus.fld_last  = 1'b0;

        // ---- reset ----
        tick();
        tick();
        check("rst_ready_low", 32'(bus.fld_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_ready_high", 32'(bus.fld_ready), 32'd1);
        check_reset_vals("rst");

        // ---- single word ----
        push(6'h0A, 5'h03, 5'h1F, 8'hA5, 1'b1);
        check("s1_fifo", 32'(dbg_fifo_count), 32'd1);
        exp_q.push_back({8'h10, 24'h287FA5});
        pulse_start(8'h10);
        check("s1_state_load", 32'(dbg_state), 32'(ST_LOAD));
        check("s1_we_before", 32'(bus.imem_we), 32'd0);
        tick();
        check("s1_we", 32'(bus.imem_we), 32'd1);
        check("s1_addr", 32'(bus.imem_addr), 32'h10);
        check("s1_wdata", 32'(bus.imem_wdata), 32'h287FA5);
        check("s1_done", 32'(load_done), 32'd1);
        check("s1_count", 32'(load_count), 32'd1);
        check("s1_hold_write", 32'(cpu_hold), 32'd1);
        tick();
        check("s1_we_after", 32'(bus.imem_we), 32'd0);
        check("s1_hold_fall", 32'(cpu_hold), 32'd0);
        check("s1_addr_hold", 32'(bus.imem_addr), 32'h10);
        check("s1_wdata_hold", 32'(bus.imem_wdata), 32'h287FA5);
        check("s1_state_done", 32'(dbg_state), 32'(ST_DONE));

        // ---- prefill and back pressure ----
        for (int k = 0; k < 8; k++) begin
            push(6'(k + 1), 5'h00, 5'h00, 8'(8'h11 + k), 1'b0);
        end
        check("s2_ready_full", 32'(bus.fld_ready), 32'd0);
        check("s2_fifo_full", 32'(dbg_fifo_count), 32'd8);
        push(6'h09, 5'h00, 5'h00, 8'h19, 1'b1);
        check("s2_ninth_rejected", 32'(dbg_fifo_count), 32'd8);
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back({8'(8'h20 + k), tbl2[k]});
        end
        pulse_start(8'h20);
        check("s2_hold_load", 32'(cpu_hold), 32'd1);
        check("s2_done_clr", 32'(load_done), 32'd0);
        tick();
        check("s2_first_addr", 32'(bus.imem_addr), 32'h20);
        check("s2_first_wdata", 32'(bus.imem_wdata), 32'h040011);
        check("s2_ready_again", 32'(bus.fld_ready), 32'd1);
        push(6'h09, 5'h00, 5'h00, 8'h19, 1'b1);
        for (int c = 0; c < 40; c++) begin
            if (load_done === 1'b1) break;
            tick();
        end
        check("s2_done", 32'(load_done), 32'd1);
        check("s2_count", 32'(load_count), 32'd9);
        check("s2_last_addr", 32'(bus.imem_addr), 32'h28);
        check("s2_fifo_empty", 32'(dbg_fifo_count), 32'd0);
        tick();
        check("s2_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- empty stall ----
        pulse_start(8'h50);
        tick();
        tick();
        check("s3_stall_we", 32'(bus.imem_we), 32'd0);
        check("s3_stall_state", 32'(dbg_state), 32'(ST_LOAD));
        check("s3_stall_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({8'(8'h50 + i), tbl3[i]});
            push(op3[i], des3[i], src3[i], imm3[i], (i == 2));
            check("s3_no_bypass", 32'(bus.imem_we), 32'd0);
            tick();
            check("s3_we", 32'(bus.imem_we), 32'd1);
            check("s3_addr", 32'(bus.imem_addr), 32'(8'h50 + i));
            check("s3_wdata", 32'(bus.imem_wdata), 32'(tbl3[i]));
            tick();
            check("s3_gap_we", 32'(bus.imem_we), 32'd0);
            tick();
        end
        check("s3_done", 32'(load_done), 32'd1);
        check("s3_count", 32'(load_count), 32'd3);
        check("s3_queue_drained", 32'(exp_q.size()), 32'd0);

        // ---- overflow at top address ----
        push(6'h01, 5'h01, 5'h01, 8'h01, 1'b0);
        push(6'h02, 5'h02, 5'h02, 8'h02, 1'b0);
        push(6'h03, 5'h03, 5'h03, 8'h03, 1'b1);
        exp_q.push_back({8'hFE, 24'h042101});
        exp_q.push_back({8'hFF, 24'h084202});
        pulse_start(8'hFE);
        tick();
        check("s4_addr_fe", 32'(bus.imem_addr), 32'hFE);
        check("s4_err_early", 32'(load_err), 32'd0);
        tick();
        check("s4_addr_ff", 32'(bus.imem_addr), 32'hFF);
        check("s4_wdata_ff", 32'(bus.imem_wdata), 32'h084202);
        check("s4_err", 32'(load_err), 32'd1);
        check("s4_done", 32'(load_done), 32'd0);
        check("s4_state", 32'(dbg_state), 32'(ST_DONE));
        check("s4_hold_write", 32'(cpu_hold), 32'd1);
        tick();
        check("s4_no_more_we", 32'(bus.imem_we), 32'd0);
        check("s4_hold_fall", 32'(cpu_hold), 32'd0);
        check("s4_count", 32'(load_count), 32'd2);
        check("s4_leftover", 32'(dbg_fifo_count), 32'd1);

        // ---- reload picks up the leftover word ----
        exp_q.push_back({8'h40, 24'h0C6303});
        pulse_start(8'h40);
        check("s5_hold", 32'(cpu_hold), 32'd1);
        check("s5_err_clr", 32'(load_err), 32'd0);
        check("s5_done_clr", 32'(load_done), 32'd0);
        check("s5_count_clr", 32'(load_count), 32'd0);
        tick();
        check("s5_addr", 32'(bus.imem_addr), 32'h40);
        check("s5_wdata", 32'(bus.imem_wdata), 32'h0C6303);
        check("s5_done", 32'(load_done), 32'd1);
        check("s5_count", 32'(load_count), 32'd1);
        tick();

        // ---- reset mid-load ----
        for (int k = 0; k < 5; k++) begin
            push(6'(k + 1), 5'h00, 5'h00, 8'(8'h11 + k), 1'b0);
        end
        exp_q.push_back({8'h60, 24'h040011});
        exp_q.push_back({8'h61, 24'h080012});
        pulse_start(8'h60);
        tick();
        check("s6_w1", 32'(bus.imem_addr), 32'h60);
        tick();
        check("s6_w2", 32'(bus.imem_addr), 32'h61);
        rst = 1'b1;
        tick();
        check("s6_rst_ready", 32'(bus.fld_ready), 32'd0);
        check_reset_vals("s6_rst");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("s6_idle_we", 32'(bus.imem_we), 32'd0);
        end
        check("s6_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("s6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
